// File: rtl/flow_pop_arbiter_if.sv
// rtl/flow_pop_arbiter_if.sv - child pop/response and egress signals of the root pop arbiter
interface flow_pop_arbiter_if #(
  parameter int NUM_FLOWS = 4,
  parameter int W_BITS    = 4
);
  localparam int FLOW_BITS = $clog2(NUM_FLOWS);

  logic [NUM_FLOWS-1:0]        can_pop;
  logic [NUM_FLOWS-1:0]        pop;
  logic [NUM_FLOWS-1:0]        pop_valid;
  logic [NUM_FLOWS*32-1:0]     pop_value;
  logic [NUM_FLOWS*W_BITS-1:0] weight;
  logic                        out_valid;
  logic                        out_ready;
  logic [31:0]                 out_value;
  logic [FLOW_BITS-1:0]        out_flow;
  logic                        err;

  // Arbiter side
  modport master (
    input  can_pop, pop_valid, pop_value, weight, out_ready,
    output pop, out_valid, out_value, out_flow, err
  );

  // Children plus egress consumer side
  modport slave (
    output can_pop, pop_valid, pop_value, weight, out_ready,
    input  pop, out_valid, out_value, out_flow, err
  );
endinterface

// File: rtl/flow_pop_arbiter.sv
// rtl/flow_pop_arbiter.sv - weighted round-robin pop arbiter over per-flow PIFO children
module flow_pop_arbiter #(
  parameter int NUM_FLOWS = 4,
  parameter int W_BITS    = 4,
  localparam int FLOW_BITS = $clog2(NUM_FLOWS)
) (
  input  logic clk,
  input  logic rst,
  flow_pop_arbiter_if.master bus
);

  localparam logic [FLOW_BITS-1:0] LAST_FLOW = FLOW_BITS'(NUM_FLOWS - 1);

  logic [FLOW_BITS-1:0] ptr, ptr_nxt;
  logic [W_BITS-1:0]    credit, credit_nxt;
  logic                 inflight;
  logic [FLOW_BITS-1:0] inflight_flow;

  logic [FLOW_BITS-1:0] grant_idx;
  logic [FLOW_BITS-1:0] cand;
  logic                 found;
  logic [W_BITS-1:0]    grant_weight;
  logic [NUM_FLOWS-1:0] pop_c;
  logic                 gate_open;
  logic                 issue;

  logic [31:0]          buf_value [2];
  logic [FLOW_BITS-1:0] buf_flow  [2];
  logic                 rd_ptr, wr_ptr;
  logic [1:0]           count;
  logic                 err_q;

  logic [NUM_FLOWS-1:0] pv_expected;
  logic                 resp_err;
  logic                 wr_en;
  logic                 rd_en;
  logic [31:0]          wr_value;

  // Buffer space must cover both stored entries and the response still in flight
  assign gate_open = (count + {1'b0, inflight}) < 2'd2;

  // Find the first non-empty flow after ptr, wrapping round to ptr itself last
  always_comb begin
    found     = 1'b0;
    grant_idx = ptr;
    cand      = ptr;
    for (int i = 1; i <= NUM_FLOWS; i++) begin
      cand = FLOW_BITS'((int'(ptr) + i) % NUM_FLOWS);
      if (!found && bus.can_pop[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant_weight = bus.weight[int'(grant_idx)*W_BITS +: W_BITS];
  end

  // Either keep spending credit on the current flow or move to the next non-empty one
  always_comb begin
    pop_c      = '0;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    if (gate_open) begin
      if (bus.can_pop[ptr] && credit != '0) begin
        pop_c[ptr] = 1'b1;
        credit_nxt = credit - 1'b1;
      end else if (found) begin
        pop_c[grant_idx] = 1'b1;
        ptr_nxt          = grant_idx;
        // A zero weight still earns one pop per round
        credit_nxt       = (grant_weight == '0) ? '0 : grant_weight - 1'b1;
      end
    end
    issue = |pop_c;
  end

  // Classify the child response: only the flow popped last cycle may answer
  always_comb begin
    pv_expected = inflight ? (NUM_FLOWS'(1) << inflight_flow) : '0;
    resp_err    = |(bus.pop_valid & ~pv_expected);
    wr_en       = inflight && bus.pop_valid[inflight_flow] && !resp_err;
    rd_en       = (count != 2'd0) && bus.out_ready;
    wr_value    = bus.pop_value[int'(inflight_flow)*32 +: 32];
  end

  // Arbitration state, in-flight tracking, sticky error and the 2-entry egress FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= LAST_FLOW;
      credit        <= '0;
      inflight      <= 1'b0;
      inflight_flow <= '0;
      err_q         <= 1'b0;
      count         <= 2'd0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_value[i] <= '0;
        buf_flow[i]  <= '0;
      end
    end else begin
      ptr      <= ptr_nxt;
      credit   <= credit_nxt;
      inflight <= issue;
      if (issue) begin
        inflight_flow <= ptr_nxt;
      end
      if (resp_err) begin
        err_q <= 1'b1;
      end
      if (wr_en) begin
        buf_value[wr_ptr] <= wr_value;
        buf_flow[wr_ptr]  <= inflight_flow;
        wr_ptr            <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.pop       = pop_c;
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_value = buf_value[rd_ptr];
  assign bus.out_flow  = buf_flow[rd_ptr];
  assign bus.err       = err_q;

endmodule

// File: tb/tb_flow_pop_arbiter.sv
// tb/tb_flow_pop_arbiter.sv - directed bench for the root weighted round-robin pop arbiter
module tb_flow_pop_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flow_pop_arbiter_if #(.NUM_FLOWS(4), .W_BITS(4)) bus ();

  flow_pop_arbiter #(.NUM_FLOWS(4), .W_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  int          cnt   [4];
  int          taken [4];
  logic [31:0] base  [4];
  logic [31:0] nxt_val [4];
  logic [3:0]  nxt_pv;
  logic [3:0]  force_pv;

  int          log_flow [$];
  logic [31:0] log_val  [$];
  int          pop_count;
  logic [3:0]  last_pop;
  logic        last_ov;
  logic [1:0]  last_flow;
  int          exp_seq [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_pins();
    for (int f = 0; f < 4; f++) begin
      bus.can_pop[f] = (cnt[f] != 0);
      if (nxt_pv[f]) bus.pop_value[32*f +: 32] = nxt_val[f];
    end
    bus.pop_valid = nxt_pv | force_pv;
  endtask

  // One clock: sample at negedge, model the children, drive new pins just after posedge
  task automatic tick();
    @(negedge clk);
    last_pop  = bus.pop;
    last_ov   = bus.out_valid;
    last_flow = bus.out_flow;
    if (bus.out_valid && bus.out_ready) begin
      log_flow.push_back(int'(bus.out_flow));
      log_val.push_back(bus.out_value);
    end
    nxt_pv = '0;
    if (!rst) begin
      for (int f = 0; f < 4; f++) begin
        if (bus.pop[f]) begin
          pop_count++;
          nxt_pv[f]  = 1'b1;
          nxt_val[f] = base[f] + 32'(taken[f]);
          taken[f]++;
          if (cnt[f] > 0) cnt[f]--;
        end
      end
    end
    @(posedge clk);
    #1;
    drive_pins();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_all();
    rst = 1'b1;
    for (int f = 0; f < 4; f++) begin
      cnt[f]   = 0;
      taken[f] = 0;
      base[f]  = 32'h1000_0000 * 32'(f + 1);
    end
    force_pv      = '0;
    nxt_pv        = '0;
    bus.weight    = {4'd1, 4'd1, 4'd1, 4'd1};
    bus.out_ready = 1'b1;
    drive_pins();
    ticks(2);
    chk("rst_pop", 32'(bus.pop), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_value", bus.out_value, 32'h0);
    chk("rst_out_flow", 32'(bus.out_flow), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    rst = 1'b0;
    log_flow.delete();
    log_val.delete();
    pop_count = 0;
  endtask

  // Compare the egress log to the expected flow order; values must run consecutively per flow
  task automatic check_log(input string tag);
    int seen [4];
    for (int f = 0; f < 4; f++) seen[f] = 0;
    chk({tag, "_len"}, 32'(log_flow.size()), 32'(exp_seq.size()));
    for (int i = 0; i < log_flow.size() && i < exp_seq.size(); i++) begin
      chk($sformatf("%s_flow%0d", tag, i), 32'(log_flow[i]), 32'(exp_seq[i]));
      if (log_flow[i] >= 0 && log_flow[i] < 4) begin
        chk($sformatf("%s_val%0d", tag, i), log_val[i], base[log_flow[i]] + 32'(seen[log_flow[i]]));
        seen[log_flow[i]]++;
      end
    end
  endtask

  initial begin
    bus.pop_value = '0;
    bus.pop_valid = '0;
    bus.can_pop   = '0;

    // Equal weights, all flows hold 3: strict rotation starting at flow 0, 2-cycle latency
    reset_all();
    for (int f = 0; f < 4; f++) cnt[f] = 3;
    drive_pins();
    tick();
    chk("t1_first_pop", 32'(last_pop), 32'h1);
    chk("t1_first_ov", 32'(last_ov), 32'h0);
    tick();
    chk("t1_second_pop", 32'(last_pop), 32'h2);
    chk("t1_lat_ov_t1", 32'(last_ov), 32'h0);
    tick();
    chk("t1_lat_ov_t2", 32'(last_ov), 32'h1);
    chk("t1_lat_flow", 32'(last_flow), 32'h0);
    ticks(30);
    exp_seq.delete();
    for (int i = 0; i < 12; i++) exp_seq.push_back(i % 4);
    check_log("t1");
    chk("t1_idle_pop", 32'(bus.pop), 32'h0);

    // Weights f0=3, f1=1 with only f0/f1 non-empty
    reset_all();
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd3};
    cnt[0] = 10;
    cnt[1] = 10;
    drive_pins();
    ticks(60);
    exp_seq = '{0,0,0,1, 0,0,0,1, 0,0,0,1, 0,1,1,1, 1,1,1,1};
    check_log("t2");

    // Stalled egress: two pops fill the buffer, head held, then resume without loss
    reset_all();
    for (int f = 0; f < 4; f++) cnt[f] = 5;
    bus.out_ready = 1'b0;
    drive_pins();
    ticks(8);
    chk("t3_pops_stalled", 32'(pop_count), 32'd2);
    chk("t3_pop_now", 32'(bus.pop), 32'h0);
    chk("t3_ov", 32'(bus.out_valid), 32'h1);
    chk("t3_head_val", bus.out_value, base[0]);
    chk("t3_head_flow", 32'(bus.out_flow), 32'h0);
    ticks(3);
    chk("t3_head_val_held", bus.out_value, base[0]);
    chk("t3_pops_held", 32'(pop_count), 32'd2);
    bus.out_ready = 1'b1;
    ticks(45);
    chk("t3_pops_total", 32'(pop_count), 32'd20);
    exp_seq.delete();
    for (int i = 0; i < 20; i++) exp_seq.push_back(i % 4);
    check_log("t3");

    // Single element on flow 2
    reset_all();
    base[2] = 32'h0000_DEAD;
    cnt[2]  = 1;
    drive_pins();
    tick();
    chk("t4_pop", 32'(last_pop), 32'h4);
    ticks(6);
    chk("t4_pop_count", 32'(pop_count), 32'd1);
    chk("t4_pop_idle", 32'(bus.pop), 32'h0);
    exp_seq = '{2};
    check_log("t4");

    // Weight 0 on flow 1 acts as 1; stray response sets sticky err
    reset_all();
    bus.weight = {4'd1, 4'd1, 4'd0, 4'd1};
    cnt[0] = 4;
    cnt[1] = 4;
    drive_pins();
    ticks(30);
    exp_seq = '{0,1,0,1,0,1,0,1};
    check_log("t5");
    chk("t5_err_clean", 32'(bus.err), 32'h0);
    force_pv = 4'b1000;
    drive_pins();
    tick();
    force_pv = '0;
    drive_pins();
    tick();
    chk("t5_err_set", 32'(bus.err), 32'h1);
    chk("t5_err_not_buffered", 32'(bus.out_valid), 32'h0);
    ticks(4);
    chk("t5_err_sticky", 32'(bus.err), 32'h1);
    rst = 1'b1;
    tick();
    chk("t5_err_cleared", 32'(bus.err), 32'h0);
    rst = 1'b0;

    // Reset lands on the response cycle: response dropped, ptr restarts before flow 0
    reset_all();
    cnt[1] = 3;
    drive_pins();
    tick();
    chk("t6_pop_f1", 32'(last_pop), 32'h2);
    rst = 1'b1;
    cnt[0] = 2;
    cnt[2] = 2;
    drive_pins();
    tick();
    rst = 1'b0;
    chk("t6_ov_after_rst", 32'(bus.out_valid), 32'h0);
    log_flow.delete();
    log_val.delete();
    tick();
    chk("t6_restart_pop", 32'(last_pop), 32'h1);
    chk("t6_no_stale_ov", 32'(last_ov), 32'h0);
    ticks(3);
    chk("t6_first_out_flow", 32'(log_flow.size() > 0 ? log_flow[0] : -1), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
